// File: rtl/pcpu_pkg.sv
// rtl/pcpu_pkg.sv - shared pipeline constants and IF-stage types
package pcpu_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } if_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/acknowledge bundle
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with hold / +4 / load select
module pc_reg
    import pcpu_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     sel,
    input  logic [29:0] load_word,
    output logic [31:0] pc
);

    // Only the word index is stored, so the low two bits are zero by construction.
    logic [29:0] pc_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_word <= RESET_VAL[31:2];
        end else begin
            case (sel)
                PC_INC:  pc_word <= pc_word + 30'd1;
                PC_LOAD: pc_word <= load_word;
                default: pc_word <= pc_word;
            endcase
        end
    end

    assign pc = {pc_word, 2'b00};

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, imem handshake, IF/ID presentation
module if_stage
    import pcpu_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst
);

    if_state_e   state;
    logic [29:0] target;
    logic [31:0] hold_inst;
    logic [31:0] pc;
    pc_sel_e     pc_sel;
    logic [29:0] load_word;
    logic        ack;
    logic        present;
    logic        unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    pc_reg #(.RESET_VAL(RESET_VAL)) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .sel       (pc_sel),
        .load_word (load_word),
        .pc        (pc)
    );

    assign imem.imem_req  = !rst && (state != HOLD);
    assign imem.imem_addr = pc;
    assign ack            = imem.imem_req && imem.imem_ack;

    always_comb begin
        pc_sel    = PC_HOLD;
        load_word = redirect_pc[31:2];
        present   = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (ack) pc_sel = PC_LOAD;
                end else if (ack) begin
                    present = 1'b1;
                    if (!stall) pc_sel = PC_INC;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_sel = PC_LOAD;
                end else begin
                    present = 1'b1;
                    if (!stall) pc_sel = PC_INC;
                end
            end
            DISCARD: begin
                // A redirect arriving on the discarded ack beats the stored target.
                if (ack) begin
                    pc_sel = PC_LOAD;
                    if (!redirect) load_word = target;
                end
            end
            default: ;
        endcase
    end

    assign if_valid = present && !rst;
    assign if_pc    = if_valid ? pc : NOP;
    assign if_inst  = !if_valid       ? NOP :
                      (state == HOLD) ? hold_inst : imem.imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            target    <= '0;
            hold_inst <= NOP;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (!ack) begin
                            target <= redirect_pc[31:2];
                            state  <= DISCARD;
                        end
                    end else if (ack && stall) begin
                        hold_inst <= imem.imem_rdata;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) state <= FETCH;
                end
                DISCARD: begin
                    if (redirect) target <= redirect_pc[31:2];
                    if (ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        tie_ack;
    logic        man_ack;
    logic [31:0] man_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    int          total;
    int          bad;

    if_stage_if imem();

    assign imem.imem_ack   = tie_ack ? imem.imem_req : man_ack;
    assign imem.imem_rdata = tie_ack ? (imem.imem_addr | 32'h1) : man_rdata;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        next_cycle();
        next_cycle();
        #1;
        total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem.imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
        total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", if_inst); end
    endtask

    task automatic test_zero_wait;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            rst = 1'b0;
            tie_ack = 1'b1;
            #1;
            total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, if_valid); end
            total++; if (if_pc !== 32'(4 * i)) begin bad++; $display("FAIL zw_pc[%0d] got=%h exp=%h", i, if_pc, 32'(4 * i)); end
            total++; if (if_inst !== 32'(4 * i + 1)) begin bad++; $display("FAIL zw_inst[%0d] got=%h exp=%h", i, if_inst, 32'(4 * i + 1)); end
        end
    endtask

    task automatic test_delayed_ack;
        logic [31:0] base;
        for (int k = 0; k < 2; k++) begin
            base = 32'h10 + 32'(4 * k);
            for (int c = 0; c < 4; c++) begin
                next_cycle();
                tie_ack   = 1'b0;
                man_ack   = (c == 3);
                man_rdata = 32'hA000_0000 + 32'(k);
                #1;
                total++; if (imem.imem_addr !== base) begin bad++; $display("FAIL dly_addr[%0d.%0d] got=%h exp=%h", k, c, imem.imem_addr, base); end
                if (c < 3) begin
                    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL dly_idle[%0d.%0d] got=%b exp=0", k, c, if_valid); end
                end else begin
                    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL dly_valid[%0d] got=%b exp=1", k, if_valid); end
                    total++; if (if_pc !== base) begin bad++; $display("FAIL dly_pc[%0d] got=%h exp=%h", k, if_pc, base); end
                    total++; if (if_inst !== 32'hA000_0000 + 32'(k)) begin bad++; $display("FAIL dly_inst[%0d] got=%h exp=%h", k, if_inst, 32'hA000_0000 + 32'(k)); end
                end
            end
        end
    endtask

    task automatic test_stall_hold;
        next_cycle();
        man_ack = 1'b1; stall = 1'b1; man_rdata = 32'hDEAD_0001;
        #1;
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stl_ack_valid got=%b exp=1", if_valid); end
        total++; if (if_pc !== 32'h18) begin bad++; $display("FAIL stl_ack_pc got=%h exp=18", if_pc); end
        for (int h = 0; h < 2; h++) begin
            next_cycle();
            man_ack = (h == 0); man_rdata = 32'h0BAD_0BAD; stall = (h == 0);
            #1;
            total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL hold_req[%0d] got=%b exp=0", h, imem.imem_req); end
            total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", h, if_valid); end
            total++; if (if_inst !== 32'hDEAD_0001) begin bad++; $display("FAIL hold_inst[%0d] got=%h exp=dead0001", h, if_inst); end
            total++; if (if_pc !== 32'h18) begin bad++; $display("FAIL hold_pc[%0d] got=%h exp=18", h, if_pc); end
        end
        next_cycle();
        man_ack = 1'b0; stall = 1'b0;
        #1;
        total++; if (imem.imem_req !== 1'b1) begin bad++; $display("FAIL post_hold_req got=%b exp=1", imem.imem_req); end
        total++; if (imem.imem_addr !== 32'h1C) begin bad++; $display("FAIL post_hold_addr got=%h exp=1c", imem.imem_addr); end
    endtask

    task automatic test_redirect_discard;
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h100; man_ack = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b exp=0", if_valid); end
        next_cycle();
        redirect = 1'b0;
        #1;
        total++; if (imem.imem_addr !== 32'h1C || imem.imem_req !== 1'b1) begin bad++; $display("FAIL disc_addr got=%h/%b exp=1c/1", imem.imem_addr, imem.imem_req); end
        next_cycle();
        man_ack = 1'b1; man_rdata = 32'hBAD0_0000;
        #1;
        total++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin bad++; $display("FAIL disc_drop got=%b/%h exp=0/0", if_valid, if_inst); end
        next_cycle();
        man_ack = 1'b0;
        #1;
        total++; if (imem.imem_addr !== 32'h100) begin bad++; $display("FAIL rd_target got=%h exp=100", imem.imem_addr); end
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h300;
        #1;
        next_cycle();
        redirect_pc = 32'h200;
        #1;
        total++; if (imem.imem_addr !== 32'h100) begin bad++; $display("FAIL disc2_addr got=%h exp=100", imem.imem_addr); end
        next_cycle();
        redirect = 1'b0; man_ack = 1'b1;
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL disc2_drop got=%b exp=0", if_valid); end
        next_cycle();
        man_ack = 1'b0;
        #1;
        total++; if (imem.imem_addr !== 32'h200) begin bad++; $display("FAIL rd_latest got=%h exp=200", imem.imem_addr); end
    endtask

    task automatic test_redirect_ack_stall;
        next_cycle();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h403; man_ack = 1'b1; man_rdata = 32'h1234_5678;
        #1;
        total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin bad++; $display("FAIL ras_out got=%b/%h/%h exp=0/0/0", if_valid, if_pc, if_inst); end
        next_cycle();
        stall = 1'b0; redirect = 1'b0; man_ack = 1'b0;
        #1;
        total++; if (imem.imem_req !== 1'b1) begin bad++; $display("FAIL ras_no_hold got=%b exp=1", imem.imem_req); end
        total++; if (imem.imem_addr !== 32'h400) begin bad++; $display("FAIL ras_addr got=%h exp=400", imem.imem_addr); end
    endtask

    task automatic test_wrap;
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; man_ack = 1'b1;
        #1;
        next_cycle();
        redirect = 1'b0; man_rdata = 32'h0C0F_FEE0;
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pres got=%b/%h exp=1/fffffffc", if_valid, if_pc); end
        next_cycle();
        man_ack = 1'b0;
        #1;
        total++; if (imem.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem.imem_addr); end
    endtask

    task automatic test_reset_mid;
        next_cycle();
        man_ack = 1'b1; man_rdata = 32'h11;
        #1;
        next_cycle();
        man_ack = 1'b0;
        #1;
        total++; if (imem.imem_addr !== 32'h4 || imem.imem_req !== 1'b1) begin bad++; $display("FAIL mid_pending got=%h/%b exp=4/1", imem.imem_addr, imem.imem_req); end
        next_cycle();
        rst = 1'b1; man_ack = 1'b1; man_rdata = 32'h5555;
        #1;
        total++; if (imem.imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin bad++; $display("FAIL mid_rst_out got=%b/%b/%h/%h exp=0/0/0/0", imem.imem_req, if_valid, if_pc, if_inst); end
        next_cycle();
        rst = 1'b0; man_ack = 1'b0;
        #1;
        total++; if (imem.imem_addr !== 32'h0 || if_valid !== 1'b0) begin bad++; $display("FAIL mid_after got=%h/%b exp=0/0", imem.imem_addr, if_valid); end
        next_cycle();
        man_ack = 1'b1; man_rdata = 32'h77;
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h77) begin bad++; $display("FAIL mid_refetch got=%b/%h/%h exp=1/0/77", if_valid, if_pc, if_inst); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tie_ack = 1'b1; man_ack = 1'b0; man_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_stall_hold();
        test_redirect_discard();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction Fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the instruction-memory request/acknowledge interface and presents one fetched instruction per cycle to the IF/ID pipeline register. It absorbs variable memory latency, downstream stalls and control-flow redirects from ID/EX. When no valid instruction is available it emits a bubble (all-zero instruction and PC), matching the IF/ID register's flush value.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard unit: IF/ID will not capture this cycle
- redirect  in  1  branch/jump taken; discard current fetch path
- redirect_pc  in  32  new fetch target; word aligned, bits [1:0] ignored
- imem_req  out  1  instruction memory request
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  data valid this cycle for the outstanding request
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_valid  out  1  if_pc/if_inst hold a real instruction
- if_pc  out  32  PC of presented instruction; 0 when !if_valid
- if_inst  out  32  presented instruction; 0 (NOP) when !if_valid

## Operation
- Registers: pc (32), target (32), hold_inst (32), state ∈ {FETCH, HOLD, DISCARD}.
- Memory protocol: imem_req and imem_addr are held stable from assertion until the imem_ack cycle. imem_ack may arrive in the same cycle as the request, or any number of cycles later. At most one request is outstanding. imem_ack is ignored while imem_req = 0.
- FETCH: imem_req=1, imem_addr=pc. Priority order within the state:
  - redirect and imem_ack: drop data, if_valid=0, pc←redirect_pc, stay in FETCH.
  - redirect without imem_ack: target←redirect_pc, go to DISCARD, if_valid=0.
  - imem_ack and !stall: present imem_rdata combinationally with if_valid=1 and if_pc=pc; pc←pc+4; stay in FETCH.
  - imem_ack and stall: present the same values (ignored downstream); hold_inst←imem_rdata; go to HOLD. pc is unchanged.
  - no imem_ack: if_valid=0.
- HOLD: imem_req=0. Present hold_inst with if_pc=pc and if_valid=1.
  - redirect: pc←redirect_pc, go to FETCH, if_valid=0.
  - !stall: pc←pc+4, go to FETCH.
  - stall: remain in HOLD.
- DISCARD: imem_req=1, imem_addr=old pc (stable), if_valid=0.
  - redirect: target←redirect_pc (latest wins).
  - imem_ack: data dropped; pc←(redirect ? redirect_pc : target); go to FETCH.
- redirect always overrides stall.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] of pc are forced to 0.

## Timing
- Reset: pc=RESET_PC, state=FETCH. During rst: imem_req=0, if_valid=0, if_pc=0, if_inst=0.
- The first imem_req is asserted in the cycle after rst is deasserted.
- Zero-wait memory (ack in the request cycle): 1 instruction/cycle, with combinational imem_rdata→if_inst and no added latency.
- A redirect takes effect on imem_addr in the next cycle (FETCH or HOLD), or one cycle after the discarded ack (DISCARD).
- rst mid-request: all state cleared. A late ack arriving after reset, while imem_req=0, is ignored.

## Structure
- The shared package pcpu_pkg holds:
  - the NOP encoding (32'h0);
  - the if_state enum;
  - the default RESET_PC constant.
- One natural sub-module: pc_reg. It implements the PC register with its load-select (hold / +4 / redirect) and forced alignment. The FSM, hold buffer and output mux stay in if_stage.

## Test plan
- Reset release, imem_ack tied to imem_req, rdata=addr|1: if_pc sequence 0,4,8,C with if_valid=1 every cycle from the first post-reset cycle.
- Ack delayed 3 cycles per request: imem_addr is stable for 4 cycles, if_valid is high exactly 1 cycle per instruction, and pc advances by 4 each time.
- Ack with stall=1 for 2 cycles, then stall=0: HOLD for 2 cycles with if_inst=hold_inst and imem_req=0, then FETCH of pc+4.
- Redirect to 0x100 while an ack is pending: imem_addr stays at the old value until ack, that data is dropped (if_valid=0), and the next imem_addr is 0x100. A second redirect to 0x200 during DISCARD gives 0x200.
- Redirect and ack in the same cycle, with stall=1: if_valid=0, no HOLD, and next imem_addr=redirect_pc.
- pc=0xFFFF_FFFC acked: the next imem_addr is 0. Assert rst during an outstanding request: outputs are zero next cycle, and a stale ack is ignored.
